wb_prio_arbiter: RTL and testbench
==================================

// Module: wb_prio_arbiter
// PURPOSE
//  Shares one Wishbone slave (main memory) between NUM_MASTERS bus masters (OR1200 data + instruction ports).
//  Fixed priority, highest master index first, with starvation aging and whole-cycle (burst) grant locking.
//  Optional bus watchdog.
//  Sits between the per-master address muxes and the memory slave port.
// PARAMETERS
//  NUM_MASTERS     2    number of requesting masters (>=2)
//  STARVE_LIMIT    8    wait cycles after which a pending master becomes urgent (1..255)
//  TIMEOUT_CYCLES  255  stb-without-termination cycles before forced err (only with WB_PRIO_ARB_TIMEOUT_EN)
// PORTS
//  wb_clk_i      in   1               bus clock
//  wb_rst_i      in   1               async reset, active-high
//  wbm_adr_i     in   NUM_MASTERS*32  master addresses, master k at [k*32+:32]
//  wbm_dat_i     in   NUM_MASTERS*32  master write data
//  wbm_sel_i     in   NUM_MASTERS*4   byte selects
//  wbm_we_i      in   NUM_MASTERS     write enables
//  wbm_cyc_i     in   NUM_MASTERS     cycle requests
//  wbm_stb_i     in   NUM_MASTERS     strobes
//  wbm_cti_i     in   NUM_MASTERS*3   cycle type ids
//  wbm_bte_i     in   NUM_MASTERS*2   burst type ext
//  wbm_dat_o     out  NUM_MASTERS*32  read data, slave data broadcast to all
//  wbm_ack_o     out  NUM_MASTERS     ack, granted master only
//  wbm_err_o     out  NUM_MASTERS     err, granted master only
//  wbm_rty_o     out  NUM_MASTERS     rty, granted master only
//  wbs_adr_o     out  32              slave address, from granted master
//  wbs_dat_o     out  32              slave write data
//  wbs_sel_o     out  4               slave byte selects
//  wbs_we_o      out  1               slave write enable
//  wbs_cyc_o     out  1               slave cycle
//  wbs_stb_o     out  1               slave strobe
//  wbs_cti_o     out  3               slave cti
//  wbs_bte_o     out  2               slave bte
//  wbs_dat_i     in   32              slave read data
//  wbs_ack_i     in   1               slave ack
//  wbs_err_i     in   1               slave err
//  wbs_rty_i     in   1               slave rty
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, grant=0, age counters=0, all wbs cyc/stb and wbm ack/err/rty = 0.
//  FSM IDLE: if any wbm_cyc_i, register winner and go to GRANT. Arbitration latency is 1 cycle; no slave cyc in IDLE.
//  Winner: among urgent masters (age==STARVE_LIMIT), lowest index wins; if none urgent, highest requesting index wins.
//  GRANT: route granted master's adr/dat/sel/we/cti/bte; wbs_cyc_o/stb_o = granted cyc/stb.
//   Ack/err/rty pass combinationally to the granted master; other masters see 0.
//  Grant is held for the whole cyc (bursts, cti 3'b010 and 3'b111 included), with no pre-emption.
//  Granted cyc low -> IDLE next cycle (1 dead cycle). Same master re-requesting is re-arbitrated normally.
//  Age counter per master: +1 per cycle while cyc high and not granted, saturating at STARVE_LIMIT.
//   It clears when that master is granted or its cyc drops.
//  Non-granted masters may hold cyc/stb indefinitely; they never see termination.
//  wbs_dat_o etc. are don't-care while wbs_cyc_o=0. Slave terminations in IDLE are ignored.
// CONFIGURATION
//  WB_PRIO_ARB_TIMEOUT_EN defined: a counter runs in GRANT while stb high and no ack/err/rty.
//   It clears on any termination or stb low. On reaching TIMEOUT_CYCLES: 1-cycle wbm_err_o to the granted master.
//   wbs_cyc_o/stb_o are forced low that cycle and FSM -> IDLE; the next cycle re-arbitrates.
//  Macro undefined: no counter; waits indefinitely for termination; TIMEOUT_CYCLES is unused.
// STRUCTURE
//  Package wb_prio_arb_pkg: FSM state encodings (IDLE, GRANT), CTI constants (CLASSIC, INCR, EOB).
//  Age counter width = $clog2(STARVE_LIMIT+1).
//  Sub-module wb_prio_arb_pick: combinational winner select from cyc vector and urgent vector, one-hot + index out.
// TESTING
//  1 Reset asserted mid-burst -> wbs_cyc_o=0 and all wbm_ack_o=0 in the same cycle; grant=0 after release.
//  2 M0, M1 cyc rise in same cycle, single reads -> M1 is served first; M0 is granted 1 cycle after M1 cyc drops.
//  3 M1 does a 4-beat INCR burst (cti 010,010,010,111) while M0 requests -> 4 acks to M1, no cyc gap, then M0.
//  4 M1 back-to-back cycles, M0 waiting, STARVE_LIMIT=8 -> M0 is granted at the first IDLE after age reaches 8.
//  5 TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never acks -> wbm_err_o of the granted master=1 on cycle 16, cyc low, IDLE.
//  6 Slave err/rty on beat 2 -> routed only to the granted master; other masters' err/rty stay 0.

Source files
------------

// File: rtl/wb_prio_arb_pkg.sv
// Shared definitions for the Wishbone priority arbiter.
// Holds the FSM state encoding and the Wishbone cycle-type identifiers.
package wb_prio_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb_prio_arb_pick.sv
// Combinational winner select for the Wishbone priority arbiter.
// Urgent (starved) requesters take precedence, lowest index first.
// Otherwise the highest requesting index wins.
module wb_prio_arb_pick
  import wb_prio_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] cyc,
  input  logic [NUM_MASTERS-1:0] urgent,
  output logic [NUM_MASTERS-1:0] win_onehot,
  output logic [IDX_W-1:0]       win_idx,
  output logic                   win_any
);

  logic found;

  // Priority scan: urgent lowest-index first, then highest plain requester.
  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    found      = 1'b0;
    win_any    = |cyc;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!found && cyc[k] && urgent[k]) begin
        win_idx = IDX_W'(k);
        found   = 1'b1;
      end
    end
    if (!found) begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        if (cyc[k]) begin
          win_idx = IDX_W'(k);
        end
      end
    end
    if (win_any) begin
      win_onehot[win_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/wb_prio_arbiter.sv
// Wishbone fixed-priority arbiter with starvation aging and whole-cycle
// grant locking, sharing one slave port between NUM_MASTERS masters.
// Optional bus watchdog enabled by defining WB_PRIO_ARB_TIMEOUT_EN.
module wb_prio_arbiter
  import wb_prio_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int STARVE_LIMIT   = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [NUM_MASTERS*32-1:0] wbm_adr_i,
  input  logic [NUM_MASTERS*32-1:0] wbm_dat_i,
  input  logic [NUM_MASTERS*4-1:0]  wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]    wbm_we_i,
  input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
  input  logic [NUM_MASTERS*3-1:0]  wbm_cti_i,
  input  logic [NUM_MASTERS*2-1:0]  wbm_bte_i,
  output logic [NUM_MASTERS*32-1:0] wbm_dat_o,
  output logic [NUM_MASTERS-1:0]    wbm_ack_o,
  output logic [NUM_MASTERS-1:0]    wbm_err_o,
  output logic [NUM_MASTERS-1:0]    wbm_rty_o,
  output logic [31:0]               wbs_adr_o,
  output logic [31:0]               wbs_dat_o,
  output logic [3:0]                wbs_sel_o,
  output logic                      wbs_we_o,
  output logic                      wbs_cyc_o,
  output logic                      wbs_stb_o,
  output logic [2:0]                wbs_cti_o,
  output logic [1:0]                wbs_bte_o,
  input  logic [31:0]               wbs_dat_i,
  input  logic                      wbs_ack_i,
  input  logic                      wbs_err_i,
  input  logic                      wbs_rty_i
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [AGE_W-1:0]       age_q [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] urgent;
  logic [NUM_MASTERS-1:0] win_onehot;
  logic [IDX_W-1:0]       win_idx;
  logic                   win_any;
  logic                   granted;
  logic [NUM_MASTERS-1:0] grant_vec;
  logic [NUM_MASTERS-1:0] clear_vec;
  logic                   gnt_cyc;
  logic                   gnt_stb;
  logic                   term;
  logic                   timeout_hit;

  // Starvation flags: a master is urgent once its wait count saturates.
  always_comb begin
    for (int k = 0; k < NUM_MASTERS; k++) begin
      urgent[k] = (age_q[k] == AGE_W'(STARVE_LIMIT));
    end
  end

  wb_prio_arb_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_pick (
    .cyc        (wbm_cyc_i),
    .urgent     (urgent),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .win_any    (win_any)
  );

  assign granted   = (state_q == ARB_GRANT);
  assign grant_vec = granted ? (NUM_MASTERS'(1) << grant_q) : '0;
  assign gnt_cyc   = wbm_cyc_i[grant_q];
  assign gnt_stb   = wbm_stb_i[grant_q];
  assign term      = wbs_ack_i | wbs_err_i | wbs_rty_i;

`ifdef WB_PRIO_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q;

  assign timeout_hit = granted && gnt_stb && !term &&
                       (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: count stalled strobe cycles of the granted master.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tmo_cnt_q <= '0;
    end else if (!granted || !gnt_stb || term || timeout_hit) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end
`else
  logic [31:0] unused_timeout_cycles;

  assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
  assign timeout_hit           = 1'b0;
`endif

  // Next-state logic: arbitrate in IDLE, hold the grant for the whole cycle.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      ARB_IDLE: begin
        if (win_any) begin
          grant_d = win_idx;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (!gnt_cyc || timeout_hit) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // FSM state and grant register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // Masters being granted now (arbitration win or held grant) stop aging.
  assign clear_vec = granted ? grant_vec : win_onehot;

  // Per-master wait counters, saturating at the starvation limit.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        age_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        if (!wbm_cyc_i[k] || clear_vec[k]) begin
          age_q[k] <= '0;
        end else if (!urgent[k]) begin
          age_q[k] <= age_q[k] + 1'b1;
        end
      end
    end
  end

  // Slave-side routing from the granted master; the watchdog drops cyc/stb.
  always_comb begin
    wbs_adr_o = wbm_adr_i[grant_q*32 +: 32];
    wbs_dat_o = wbm_dat_i[grant_q*32 +: 32];
    wbs_sel_o = wbm_sel_i[grant_q*4 +: 4];
    wbs_we_o  = wbm_we_i[grant_q];
    wbs_cti_o = wbm_cti_i[grant_q*3 +: 3];
    wbs_bte_o = wbm_bte_i[grant_q*2 +: 2];
    wbs_cyc_o = granted && gnt_cyc && !timeout_hit;
    wbs_stb_o = granted && gnt_stb && !timeout_hit;
  end

  // Master-side returns: data broadcast, terminations to the granted master only.
  always_comb begin
    wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};
    wbm_ack_o = grant_vec & {NUM_MASTERS{wbs_ack_i & ~timeout_hit}};
    wbm_err_o = grant_vec & {NUM_MASTERS{wbs_err_i | timeout_hit}};
    wbm_rty_o = grant_vec & {NUM_MASTERS{wbs_rty_i & ~timeout_hit}};
  end

endmodule

// File: tb/tb_wb_prio_arbiter.sv
// Directed bench for wb_prio_arbiter (two masters, STARVE_LIMIT=8,
// TIMEOUT_CYCLES=16; watchdog case only when WB_PRIO_ARB_TIMEOUT_EN is set).
module tb_wb_prio_arbiter;
  import wb_prio_arb_pkg::*;

  localparam int NM = 2;
  localparam logic [31:0] A0 = 32'h0000_1000;
  localparam logic [31:0] A1 = 32'h0000_2000;

  logic            clk = 1'b0;
  logic            rst;
  logic [NM*32-1:0] wbm_adr_i, wbm_dat_i, wbm_dat_o;
  logic [NM*4-1:0]  wbm_sel_i;
  logic [NM-1:0]    wbm_we_i, wbm_cyc_i, wbm_stb_i;
  logic [NM*3-1:0]  wbm_cti_i;
  logic [NM*2-1:0]  wbm_bte_i;
  logic [NM-1:0]    wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [31:0]      wbs_adr_o, wbs_dat_o, wbs_dat_i;
  logic [3:0]       wbs_sel_o;
  logic             wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0]       wbs_cti_o;
  logic [1:0]       wbs_bte_o;
  logic             wbs_ack_i, wbs_err_i, wbs_rty_i;

  int total = 0;
  int bad   = 0;
  int acks;

  always #5 clk = ~clk;

  wb_prio_arbiter #(
    .NUM_MASTERS    (NM),
    .STARVE_LIMIT   (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbm_adr_i (wbm_adr_i),
    .wbm_dat_i (wbm_dat_i),
    .wbm_sel_i (wbm_sel_i),
    .wbm_we_i  (wbm_we_i),
    .wbm_cyc_i (wbm_cyc_i),
    .wbm_stb_i (wbm_stb_i),
    .wbm_cti_i (wbm_cti_i),
    .wbm_bte_i (wbm_bte_i),
    .wbm_dat_o (wbm_dat_o),
    .wbm_ack_o (wbm_ack_o),
    .wbm_err_o (wbm_err_o),
    .wbm_rty_o (wbm_rty_o),
    .wbs_adr_o (wbs_adr_o),
    .wbs_dat_o (wbs_dat_o),
    .wbs_sel_o (wbs_sel_o),
    .wbs_we_o  (wbs_we_o),
    .wbs_cyc_o (wbs_cyc_o),
    .wbs_stb_o (wbs_stb_o),
    .wbs_cti_o (wbs_cti_o),
    .wbs_bte_o (wbs_bte_o),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_i (wbs_ack_i),
    .wbs_err_i (wbs_err_i),
    .wbs_rty_i (wbs_rty_i)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input int k, input logic cyc, input logic stb, input logic [2:0] cti);
    wbm_cyc_i[k]       = cyc;
    wbm_stb_i[k]       = stb;
    wbm_cti_i[k*3 +: 3] = cti;
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    wbm_cyc_i = '0;
    wbm_stb_i = '0;
    wbm_cti_i = '0;
    wbs_ack_i = 1'b0;
    wbs_err_i = 1'b0;
    wbs_rty_i = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    rst       = 1'b1;
    wbm_adr_i = {A1, A0};
    wbm_dat_i = {32'hBBBB_0001, 32'hAAAA_0000};
    wbm_sel_i = {4'hF, 4'h3};
    wbm_we_i  = 2'b01;
    wbm_bte_i = '0;
    wbs_dat_i = 32'hCAFE_F00D;

    // Reset state and terminations ignored in IDLE
    apply_reset();
    wbs_ack_i = 1'b1;
    wbs_err_i = 1'b1;
    settle();
    check_val("idle_cyc", wbs_cyc_o, 1'b0);
    check_val("idle_ack", wbm_ack_o, 2'b00);
    check_val("idle_err", wbm_err_o, 2'b00);
    wbs_ack_i = 1'b0;
    wbs_err_i = 1'b0;

    // Simultaneous requests: M1 first, then M0 after one dead cycle
    apply_reset();
    drive(0, 1, 1, CTI_CLASSIC);
    drive(1, 1, 1, CTI_CLASSIC);
    settle();
    check_val("t2_arb_latency", wbs_cyc_o, 1'b0);
    step();
    check_val("t2_m1_cyc", wbs_cyc_o, 1'b1);
    check_val("t2_m1_adr", wbs_adr_o, A1);
    check_val("t2_m1_we", wbs_we_o, 1'b0);
    wbs_ack_i = 1'b1;
    settle();
    check_val("t2_m1_ack", wbm_ack_o, 2'b10);
    check_val("t2_dat_bcast", wbm_dat_o[31:0], 32'hCAFE_F00D);
    step();
    wbs_ack_i = 1'b0;
    drive(1, 0, 0, CTI_CLASSIC);
    settle();
    check_val("t2_m1_drop", wbs_cyc_o, 1'b0);
    step();
    check_val("t2_dead", wbs_cyc_o, 1'b0);
    step();
    check_val("t2_m0_cyc", wbs_cyc_o, 1'b1);
    check_val("t2_m0_adr", wbs_adr_o, A0);
    check_val("t2_m0_dat", wbs_dat_o, 32'hAAAA_0000);
    check_val("t2_m0_sel", wbs_sel_o, 4'h3);
    wbs_ack_i = 1'b1;
    settle();
    check_val("t2_m0_ack", wbm_ack_o, 2'b01);
    wbs_ack_i = 1'b0;

    // 4-beat INCR burst by M1 with M0 waiting
    apply_reset();
    drive(0, 1, 1, CTI_CLASSIC);
    drive(1, 1, 1, CTI_INCR);
    step();
    acks = 0;
    for (int b = 0; b < 4; b++) begin
      drive(1, 1, 1, (b < 3) ? CTI_INCR : CTI_EOB);
      wbs_ack_i = 1'b1;
      settle();
      check_val("t3_burst_cyc", wbs_cyc_o, 1'b1);
      check_val("t3_burst_cti", wbs_cti_o, (b < 3) ? 32'(CTI_INCR) : 32'(CTI_EOB));
      check_val("t3_m0_no_ack", wbm_ack_o[0], 1'b0);
      if (wbm_ack_o[1]) acks++;
      step();
    end
    check_val("t3_ack_count", acks, 4);
    wbs_ack_i = 1'b0;
    drive(1, 0, 0, CTI_CLASSIC);
    step();
    check_val("t3_dead", wbs_cyc_o, 1'b0);
    step();
    check_val("t3_m0_adr", wbs_adr_o, A0);
    check_val("t3_m0_cyc", wbs_cyc_o, 1'b1);

    // Starvation: M1 back-to-back, M0 urgent after 8 waiting cycles
    apply_reset();
    drive(0, 1, 1, CTI_CLASSIC);
    for (int r = 0; r < 3; r++) begin
      drive(1, 1, 1, CTI_CLASSIC);
      settle();
      check_val("t4_idle", wbs_cyc_o, 1'b0);
      step();
      wbs_ack_i = 1'b1;
      settle();
      check_val("t4_m1_adr", wbs_adr_o, A1);
      check_val("t4_m1_ack", wbm_ack_o, 2'b10);
      step();
      wbs_ack_i = 1'b0;
      drive(1, 0, 0, CTI_CLASSIC);
      step();
    end
    drive(1, 1, 1, CTI_CLASSIC);
    settle();
    check_val("t4_idle_last", wbs_cyc_o, 1'b0);
    step();
    check_val("t4_m0_urgent_adr", wbs_adr_o, A0);
    wbs_ack_i = 1'b1;
    settle();
    check_val("t4_m0_urgent_ack", wbm_ack_o, 2'b01);
    wbs_ack_i = 1'b0;

    // err/rty on beat 2 go only to the granted master
    apply_reset();
    drive(0, 1, 1, CTI_CLASSIC);
    drive(1, 1, 1, CTI_INCR);
    step();
    wbs_ack_i = 1'b1;
    settle();
    check_val("t6_beat1_ack", wbm_ack_o, 2'b10);
    step();
    wbs_ack_i = 1'b0;
    wbs_err_i = 1'b1;
    settle();
    check_val("t6_err", wbm_err_o, 2'b10);
    check_val("t6_err_no_ack", wbm_ack_o, 2'b00);
    wbs_err_i = 1'b0;
    wbs_rty_i = 1'b1;
    settle();
    check_val("t6_rty", wbm_rty_o, 2'b10);
    check_val("t6_rty_no_err", wbm_err_o, 2'b00);
    wbs_rty_i = 1'b0;

    // Reset asserted mid-burst clears outputs immediately
    apply_reset();
    drive(1, 1, 1, CTI_INCR);
    step();
    wbs_ack_i = 1'b1;
    settle();
    check_val("t1_pre_ack", wbm_ack_o, 2'b10);
    step();
    rst = 1'b1;
    settle();
    check_val("t1_rst_cyc", wbs_cyc_o, 1'b0);
    check_val("t1_rst_stb", wbs_stb_o, 1'b0);
    check_val("t1_rst_ack", wbm_ack_o, 2'b00);
    step();
    rst       = 1'b0;
    wbs_ack_i = 1'b0;
    settle();
    check_val("t1_post_idle", wbs_cyc_o, 1'b0);
    step();
    check_val("t1_regrant_adr", wbs_adr_o, A1);
    check_val("t1_regrant_cyc", wbs_cyc_o, 1'b1);

`ifdef WB_PRIO_ARB_TIMEOUT_EN
    // Watchdog: slave never terminates, forced err on the 16th stalled cycle
    apply_reset();
    drive(0, 1, 1, CTI_CLASSIC);
    step();
    for (int i = 1; i <= 16; i++) begin
      settle();
      if (i < 16) begin
        check_val("t5_no_err", wbm_err_o, 2'b00);
      end else begin
        check_val("t5_err", wbm_err_o, 2'b01);
        check_val("t5_cyc_forced", wbs_cyc_o, 1'b0);
      end
      step();
    end
    check_val("t5_idle", wbs_cyc_o, 1'b0);
    step();
    check_val("t5_regrant", wbs_cyc_o, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
